prg_loader: RTL

PRG_LOADER -- requirements
Module: prg_loader

---
 rtl/pet_pkg.sv | 20 ++
 rtl/prg_loader_if.sv | 30 +++
 rtl/prg_loader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pet_pkg.sv
// Shared constants for the PRG loader: FSM state encodings and framing sizes.
// Pure declarations, no logic and no latency.
// No flow control of its own; imported by the loader and its bus interface.
package pet_pkg;

  // FSM state encodings (plain constants so legacy tools can consume them)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HDR_LO = 3'd1;
  localparam logic [2:0] ST_HDR_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PATCH  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // PRG files start with a two-byte little-endian load address
  localparam int HDR_LEN = 2;

  // VARTAB, ARYTAB and STREND: three little-endian pointers, six bytes in all
  localparam int PATCH_LEN = 6;

endpackage

// File: rtl/prg_loader_if.sv
// Bundle of the download-side and DMA-side signals of the PRG loader.
// Wiring only, zero latency.
// The DMA consumer takes every strobe, so no backpressure is carried here.
interface prg_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_we;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] load_addr;
  logic [15:0] end_addr;

  // Host side: streams the file in and observes the loader
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dma_addr, dma_dout, dma_we, busy, done, err, load_addr, end_addr
  );

  // Loader side
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output dma_addr, dma_dout, dma_we, busy, done, err, load_addr, end_addr
  );
endinterface

// File: rtl/prg_loader.sv
// Loads a PRG file into CPU RAM over a DMA port, then patches the BASIC end-of-program pointers.
// Latency: each accepted file byte is written one cycle after its ioctl_wr strobe.
// No backpressure: the DMA consumer accepts every strobe; out-of-range bytes are dropped and flagged.
module prg_loader
  import pet_pkg::*;
#(
  parameter logic [7:0]  INDEX    = 8'h41,
  parameter logic [15:0] RAM_TOP  = 16'h8000,
  parameter logic [15:0] PTR_BASE = 16'h002A
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_dout,
  output logic        dma_we,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] load_addr,
  output logic [15:0] end_addr
);

  logic [2:0]  state_q,     state_d;
  logic        dl_q,        dl_d;
  logic [2:0]  cnt_q,       cnt_d;
  logic [15:0] dma_addr_q,  dma_addr_d;
  logic [7:0]  dma_dout_q,  dma_dout_d;
  logic        dma_we_q,    dma_we_d;
  logic        err_q,       err_d;
  logic [15:0] load_addr_q, load_addr_d;
  logic [15:0] end_addr_q,  end_addr_d;

  logic        dl_rise;
  logic        dl_fall;
  logic [25:0] tgt_full;
  logic        tgt_ok;

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;

  // Target address with headroom above bit 15 so a wrap past 0xFFFF is visible
  assign tgt_full = {10'd0, load_addr_q} + {1'b0, ioctl_addr} - 26'(HDR_LEN);
  assign tgt_ok   = (tgt_full[25:16] == 10'd0) && (tgt_full[15:0] < RAM_TOP);

  // Next-state and registered-output computation for the load FSM
  always_comb begin
    state_d     = state_q;
    dl_d        = ioctl_download;
    cnt_d       = cnt_q;
    dma_addr_d  = dma_addr_q;
    dma_dout_d  = dma_dout_q;
    dma_we_d    = 1'b0;
    err_d       = err_q;
    load_addr_d = load_addr_q;
    end_addr_d  = end_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (dl_rise && (ioctl_index == INDEX)) begin
          state_d = ST_HDR_LO;
          err_d   = 1'b0;
        end
      end
      ST_HDR_LO: begin
        if (dl_fall) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (ioctl_wr && (ioctl_addr == 25'd0)) begin
          load_addr_d[7:0] = ioctl_dout;
          state_d          = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        if (dl_fall) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (ioctl_wr && (ioctl_addr == 25'd1)) begin
          load_addr_d[15:8] = ioctl_dout;
          end_addr_d        = {ioctl_dout, load_addr_q[7:0]};
          state_d           = ST_DATA;
        end
      end
      ST_DATA: begin
        if (ioctl_wr) begin
          if (tgt_ok) begin
            dma_we_d   = 1'b1;
            dma_addr_d = tgt_full[15:0];
            dma_dout_d = ioctl_dout;
            end_addr_d = tgt_full[15:0] + 16'd1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (dl_fall) begin
          state_d = ST_PATCH;
          cnt_d   = 3'd0;
        end
      end
      ST_PATCH: begin
        // Even offsets carry the low byte, odd offsets the high byte
        dma_we_d   = 1'b1;
        dma_addr_d = PTR_BASE + {13'd0, cnt_q};
        dma_dout_d = cnt_q[0] ? end_addr_q[15:8] : end_addr_q[7:0];
        if (cnt_q == 3'(PATCH_LEN - 1)) begin
          state_d = ST_DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; the edge detector resets high so a download
  // already in progress when reset releases is not mistaken for a new one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      dl_q        <= 1'b1;
      cnt_q       <= 3'd0;
      dma_addr_q  <= 16'd0;
      dma_dout_q  <= 8'd0;
      dma_we_q    <= 1'b0;
      err_q       <= 1'b0;
      load_addr_q <= 16'd0;
      end_addr_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      dl_q        <= dl_d;
      cnt_q       <= cnt_d;
      dma_addr_q  <= dma_addr_d;
      dma_dout_q  <= dma_dout_d;
      dma_we_q    <= dma_we_d;
      err_q       <= err_d;
      load_addr_q <= load_addr_d;
      end_addr_q  <= end_addr_d;
    end
  end

  assign dma_addr  = dma_addr_q;
  assign dma_dout  = dma_dout_q;
  assign dma_we    = dma_we_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign load_addr = load_addr_q;
  assign end_addr  = end_addr_q;

endmodule
